// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI master core among NUM_REQ requesters.
// It latches the owner's mode and divider at grant and sequences the core one byte at a time.
module spi_bus_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned DW        = 8,
    parameter int unsigned DVSR_W    = 16,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned HOLD_CYC  = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        last_i,
    input  logic [NUM_REQ*DW-1:0]     tx_data_i,
    input  logic [NUM_REQ-1:0]        cpol_i,
    input  logic [NUM_REQ-1:0]        cpha_i,
    input  logic [NUM_REQ*DVSR_W-1:0] dvsr_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      byte_ack_o,
    output logic [DW-1:0]             rx_data_o,
    output logic                      rx_valid_o,
    output logic [NUM_REQ-1:0]        ss_n_o,
    output logic                      spi_start_o,
    output logic [DW-1:0]             spi_din_o,
    output logic [DVSR_W-1:0]         spi_dvsr_o,
    output logic                      spi_cpol_o,
    output logic                      spi_cpha_o,
    input  logic [DW-1:0]             spi_dout_i,
    input  logic                      spi_done_i,
    input  logic                      spi_ready_i
);

    localparam int unsigned IW   = $clog2(NUM_REQ);
    localparam int unsigned MAXC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, rr_q, rr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, ss_n_q, ss_n_d;
    logic                ack_q, ack_d, rx_valid_q, rx_valid_d, start_q, start_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DW-1:0]       rx_data_q, rx_data_d, din_q, din_d;
    logic [DVSR_W-1:0]   dvsr_q, dvsr_d;

    logic                hi_found, lo_found;
    logic [IW-1:0]       hi_idx, lo_idx, pick;

    // First requester at or above rr_q wins; otherwise wrap to the lowest requester.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && !hi_found && (IW'(i) >= rr_q)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
            if (req_i[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
        end
        pick = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        ss_n_d     = ss_n_q;
        ack_d      = 1'b0;
        rx_valid_d = 1'b0;
        start_d    = 1'b0;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        rx_data_d  = rx_data_q;
        din_d      = din_q;
        dvsr_d     = dvsr_q;
        case (state_q)
            S_IDLE: begin
                if (lo_found) begin
                    idx_d   = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    ss_n_d  = ~(NUM_REQ'(1) << pick);
                    cpol_d  = cpol_i[pick];
                    cpha_d  = cpha_i[pick];
                    dvsr_d  = dvsr_i[pick*DVSR_W +: DVSR_W];
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (spi_ready_i) begin
                    start_d = 1'b1;
                    ack_d   = 1'b1;
                    din_d   = tx_data_i[idx_q*DW +: DW];
                    last_d  = last_i[idx_q];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (spi_done_i) begin
                    rx_data_d  = spi_dout_i;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = last_q ? S_HOLD : S_SEND;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    ss_n_d  = '1;
                    grant_d = '0;
                    rr_d    = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            ss_n_q     <= '1;
            ack_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            rx_data_q  <= '0;
            din_q      <= '0;
            dvsr_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            ss_n_q     <= ss_n_d;
            ack_q      <= ack_d;
            rx_valid_q <= rx_valid_d;
            start_q    <= start_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            rx_data_q  <= rx_data_d;
            din_q      <= din_d;
            dvsr_q     <= dvsr_d;
        end
    end

    assign grant_o     = grant_q;
    assign byte_ack_o  = ack_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign ss_n_o      = ss_n_q;
    assign spi_start_o = start_q;
    assign spi_din_o   = din_q;
    assign spi_dvsr_o  = dvsr_q;
    assign spi_cpol_o  = cpol_q;
    assign spi_cpha_o  = cpha_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a behavioural SPI core that answers din ^ key.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  req_i, last_i, cpol_i, cpha_i;
    logic [15:0] tx_data_i;
    logic [31:0] dvsr_i;
    logic [1:0]  grant_o, ss_n_o;
    logic        byte_ack_o, rx_valid_o, spi_start_o, spi_cpol_o, spi_cpha_o;
    logic [7:0]  rx_data_o, spi_din_o, spi_dout_i;
    logic [15:0] spi_dvsr_o;
    logic        spi_done_i, spi_ready_i;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.NUM_REQ(2), .DW(8), .DVSR_W(16), .SETUP_CYC(4), .HOLD_CYC(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .last_i(last_i), .tx_data_i(tx_data_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .dvsr_i(dvsr_i), .grant_o(grant_o),
        .byte_ack_o(byte_ack_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .ss_n_o(ss_n_o), .spi_start_o(spi_start_o), .spi_din_o(spi_din_o),
        .spi_dvsr_o(spi_dvsr_o), .spi_cpol_o(spi_cpol_o), .spi_cpha_o(spi_cpha_o),
        .spi_dout_i(spi_dout_i), .spi_done_i(spi_done_i), .spi_ready_i(spi_ready_i)
    );

    // Core model: busy for 4 cycles after start, then one done tick with dout = din ^ key.
    logic [7:0] key;
    logic       core_busy;
    int         core_cnt;
    always @(posedge clk) begin
        if (reset_i) begin
            core_busy <= 1'b0; core_cnt <= 0; spi_done_i <= 1'b0; spi_ready_i <= 1'b1; spi_dout_i <= '0;
        end else begin
            spi_done_i <= 1'b0;
            if (core_busy) begin
                if (core_cnt == 0) begin
                    spi_done_i <= 1'b1; spi_dout_i <= spi_din_o ^ key;
                    core_busy <= 1'b0; spi_ready_i <= 1'b1;
                end else core_cnt <= core_cnt - 1;
            end else if (spi_start_o) begin
                core_busy <= 1'b1; spi_ready_i <= 1'b0; core_cnt <= 3;
            end
        end
    end

    int tests = 0, fails = 0;
    int n_start, n_ack, n_rx, n_fall, n_rise, setup_cnt, setup_meas, hold_cnt, hold_meas;
    int gap_cnt, min_gap, cfg_err, ss_err, cur_g;
    bit started, one_shot, drop_on_ack, cfg_change_on_ack;
    logic [1:0]  ss_prev;
    logic [7:0]  rx_log [8];
    logic [7:0]  din_log [8];
    logic [1:0]  grant_log [8];
    logic        cpol_log [8];
    logic        cpha_log [8];
    logic [15:0] dvsr_log [8];
    logic        cur_cpol, cur_cpha;
    logic [15:0] cur_dvsr;
    logic [7:0]  bytes [2][4];
    int          len [2];
    int          pos [2];

    task automatic load_lane(input int g);
        if (pos[g] < len[g]) begin
            tx_data_i[g*8 +: 8] = bytes[g][pos[g]];
            last_i[g] = (pos[g] == len[g] - 1);
        end
    endtask

    task automatic clear_stats();
        n_start = 0; n_ack = 0; n_rx = 0; n_fall = 0; n_rise = 0; setup_cnt = 0; setup_meas = -1;
        hold_cnt = 0; hold_meas = -1; gap_cnt = 0; min_gap = 1000; cfg_err = 0; ss_err = 0;
        started = 1'b0; one_shot = 1'b0; drop_on_ack = 1'b0; cfg_change_on_ack = 1'b0;
        cur_g = 0; ss_prev = ss_n_o;
        for (int g = 0; g < 2; g++) begin pos[g] = 0; load_lane(g); end
    endtask

    // One clock: observe outputs at the falling edge and feed the lanes.
    task automatic tick();
        int g;
        @(negedge clk);
        g = grant_o[1] ? 1 : 0;
        if (spi_start_o) begin
            if (n_start < 8) din_log[n_start] = spi_din_o;
            n_start++;
        end
        if (byte_ack_o) begin
            n_ack++;
            pos[g]++;
            load_lane(g);
            if (drop_on_ack && g == 0) req_i[0] = 1'b0;
            if (cfg_change_on_ack && g == 0) begin
                cpol_i[0] = 1'b1; cpha_i[0] = 1'b1; dvsr_i[15:0] = 16'd99;
            end
        end
        if (rx_valid_o) begin
            if (n_rx < 8) rx_log[n_rx] = rx_data_o;
            n_rx++;
        end
        if (spi_done_i) hold_cnt = 0;
        if (ss_n_o != 2'b11) begin
            if (ss_prev == 2'b11) begin
                if (n_fall > 0 && gap_cnt < min_gap) min_gap = gap_cnt;
                if (n_fall < 8) begin
                    grant_log[n_fall] = grant_o; cpol_log[n_fall] = spi_cpol_o;
                    cpha_log[n_fall] = spi_cpha_o; dvsr_log[n_fall] = spi_dvsr_o;
                end
                cur_cpol = spi_cpol_o; cur_cpha = spi_cpha_o; cur_dvsr = spi_dvsr_o;
                n_fall++; setup_cnt = 0; started = 1'b0; cur_g = g;
                if (one_shot) req_i[g] = 1'b0;
            end
            if (spi_start_o && !started) begin started = 1'b1; setup_meas = setup_cnt; end
            else if (!started) setup_cnt++;
            if (!spi_done_i) hold_cnt++;
            if (spi_cpol_o !== cur_cpol || spi_cpha_o !== cur_cpha || spi_dvsr_o !== cur_dvsr) cfg_err++;
            if (ss_n_o !== ~grant_o) ss_err++;
        end else begin
            if (ss_prev != 2'b11) begin
                n_rise++; hold_meas = hold_cnt; gap_cnt = 0;
                pos[cur_g] = 0; load_lane(cur_g);
            end
            gap_cnt++;
        end
        ss_prev = ss_n_o;
    endtask

    task automatic run_bursts(input int target, input int budget, output bit to);
        int c = 0;
        while (n_rise < target && c < budget) begin tick(); c++; end
        to = (n_rise < target);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; tick(); tick(); reset_i = 1'b0; clear_stats();
    endtask

    task automatic test_reset();
        req_i = '0;
        reset_i = 1'b1; tick(); tick();
        tests++; if ({grant_o, ss_n_o} !== 4'b0011) begin fails++;
            $display("FAIL reset_grant_ss: got %b want 0011", {grant_o, ss_n_o}); end
        tests++; if ({byte_ack_o, rx_valid_o, spi_start_o, spi_cpol_o, spi_cpha_o} !== 5'b0) begin fails++;
            $display("FAIL reset_pulses: got %b want 00000",
                     {byte_ack_o, rx_valid_o, spi_start_o, spi_cpol_o, spi_cpha_o}); end
        tests++; if ({rx_data_o, spi_din_o, spi_dvsr_o} !== 32'h0) begin fails++;
            $display("FAIL reset_data: got %h want 0", {rx_data_o, spi_din_o, spi_dvsr_o}); end
        reset_i = 1'b0; tick();
        tests++; if (ss_n_o !== 2'b11) begin fails++;
            $display("FAIL idle_ss: got %b want 11", ss_n_o); end
        clear_stats();
    endtask

    task automatic test_single_burst();
        bit to;
        do_reset();
        key = 8'h99; bytes[0][0] = 8'hA5; len[0] = 1; clear_stats(); one_shot = 1'b1;
        req_i = 2'b01;
        run_bursts(1, 200, to);
        tests++; if (to) begin fails++; $display("FAIL t1_timeout: rises %0d want 1", n_rise); end
        tests++; if (grant_log[0] !== 2'b01) begin fails++;
            $display("FAIL t1_grant: got %b want 01", grant_log[0]); end
        tests++; if (setup_meas !== 5) begin fails++;
            $display("FAIL t1_setup: got %0d want 5 (SETUP phase plus SEND cycle)", setup_meas); end
        tests++; if (n_start !== 1 || din_log[0] !== 8'hA5) begin fails++;
            $display("FAIL t1_start: got %0d starts din %h want 1 A5", n_start, din_log[0]); end
        tests++; if (n_rx !== 1 || rx_log[0] !== 8'h3C) begin fails++;
            $display("FAIL t1_rx: got %0d x %h want 1 x 3C", n_rx, rx_log[0]); end
        tests++; if (hold_meas !== 4) begin fails++;
            $display("FAIL t1_hold: got %0d want 4", hold_meas); end
        tests++; if (ss_n_o !== 2'b11 || grant_o !== 2'b00 || ss_err !== 0) begin fails++;
            $display("FAIL t1_end: ss %b grant %b sserr %0d want 11 00 0", ss_n_o, grant_o, ss_err); end
    endtask

    task automatic test_multi_byte();
        bit to;
        do_reset();
        key = 8'hFF; bytes[0][0] = 8'h11; bytes[0][1] = 8'h22; bytes[0][2] = 8'h33; len[0] = 3;
        clear_stats(); one_shot = 1'b1;
        req_i = 2'b01;
        run_bursts(1, 300, to);
        tests++; if (to) begin fails++; $display("FAIL t2_timeout: rises %0d want 1", n_rise); end
        tests++; if (n_ack !== 3 || n_rx !== 3) begin fails++;
            $display("FAIL t2_counts: got ack %0d rx %0d want 3 3", n_ack, n_rx); end
        tests++; if ({din_log[0], din_log[1], din_log[2]} !== 24'h112233) begin fails++;
            $display("FAIL t2_din: got %h%h%h want 112233", din_log[0], din_log[1], din_log[2]); end
        tests++; if ({rx_log[0], rx_log[1], rx_log[2]} !== 24'hEEDDCC) begin fails++;
            $display("FAIL t2_rx: got %h%h%h want EEDDCC", rx_log[0], rx_log[1], rx_log[2]); end
        tests++; if (n_fall !== 1 || n_rise !== 1 || setup_meas !== 5 || hold_meas !== 4) begin fails++;
            $display("FAIL t2_phases: fall %0d rise %0d setup %0d hold %0d want 1 1 5 4",
                     n_fall, n_rise, setup_meas, hold_meas); end
    endtask

    task automatic test_round_robin();
        bit to;
        do_reset();
        key = 8'h00; bytes[0][0] = 8'hA1; bytes[1][0] = 8'hB1; len[0] = 1; len[1] = 1; clear_stats();
        req_i = 2'b11;
        run_bursts(4, 400, to);
        req_i = 2'b00;
        tests++; if (to) begin fails++; $display("FAIL t3_timeout: rises %0d want 4", n_rise); end
        tests++; if ({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== 8'b01_10_01_10) begin fails++;
            $display("FAIL t3_order: got %b %b %b %b want 01 10 01 10",
                     grant_log[0], grant_log[1], grant_log[2], grant_log[3]); end
        tests++; if (min_gap < 1 || min_gap > 100) begin fails++;
            $display("FAIL t3_gap: got %0d want >=1", min_gap); end
        tests++; if (n_rx !== 4 || rx_log[1] !== 8'hB1) begin fails++;
            $display("FAIL t3_rx: got %0d x %h want 4 x B1", n_rx, rx_log[1]); end
    endtask

    task automatic test_config();
        bit to;
        do_reset();
        key = 8'h00; cpol_i = 2'b10; cpha_i = 2'b10; dvsr_i = {16'd10, 16'd4};
        bytes[0][0] = 8'h01; bytes[0][1] = 8'h02; bytes[0][2] = 8'h03; len[0] = 3;
        bytes[1][0] = 8'h04; len[1] = 1;
        clear_stats(); one_shot = 1'b1; cfg_change_on_ack = 1'b1;
        req_i = 2'b11;
        run_bursts(2, 400, to);
        tests++; if (to) begin fails++; $display("FAIL t4_timeout: rises %0d want 2", n_rise); end
        tests++; if ({grant_log[0], cpol_log[0], cpha_log[0], dvsr_log[0]} !== {2'b01, 1'b0, 1'b0, 16'd4}) begin fails++;
            $display("FAIL t4_lane0: grant %b cpol %b cpha %b dvsr %0d want 01 0 0 4",
                     grant_log[0], cpol_log[0], cpha_log[0], dvsr_log[0]); end
        tests++; if ({grant_log[1], cpol_log[1], cpha_log[1], dvsr_log[1]} !== {2'b10, 1'b1, 1'b1, 16'd10}) begin fails++;
            $display("FAIL t4_lane1: grant %b cpol %b cpha %b dvsr %0d want 10 1 1 10",
                     grant_log[1], cpol_log[1], cpha_log[1], dvsr_log[1]); end
        tests++; if (cfg_err !== 0 || dvsr_i[15:0] !== 16'd99) begin fails++;
            $display("FAIL t4_frozen: cfg changes %0d lane0 dvsr %0d want 0 99", cfg_err, dvsr_i[15:0]); end
        cpol_i = '0; cpha_i = '0; dvsr_i = '0;
    endtask

    task automatic test_req_drop();
        bit to;
        do_reset();
        key = 8'h0F; bytes[0][0] = 8'h51; bytes[0][1] = 8'h52; bytes[0][2] = 8'h53; len[0] = 3;
        clear_stats(); drop_on_ack = 1'b1;
        req_i = 2'b01;
        run_bursts(1, 300, to);
        for (int i = 0; i < 20; i++) tick();
        tests++; if (to) begin fails++; $display("FAIL t5_timeout: rises %0d want 1", n_rise); end
        tests++; if (n_ack !== 3 || n_rx !== 3 || rx_log[2] !== 8'h5C) begin fails++;
            $display("FAIL t5_bytes: ack %0d rx %0d last %h want 3 3 5C", n_ack, n_rx, rx_log[2]); end
        tests++; if (n_fall !== 1 || req_i !== 2'b00) begin fails++;
            $display("FAIL t5_bursts: got %0d req %b want 1 00", n_fall, req_i); end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        int c = 0;
        do_reset();
        key = 8'h0F; bytes[1][0] = 8'hC3; len[1] = 1; clear_stats(); one_shot = 1'b1;
        req_i = 2'b10;
        while (n_start < 1 && c < 100) begin tick(); c++; end
        tests++; if (n_start < 1) begin fails++; $display("FAIL t6_reach_wait: starts %0d want 1", n_start); end
        reset_i = 1'b1; tick();
        tests++; if ({ss_n_o, grant_o, spi_start_o} !== 5'b11_00_0) begin fails++;
            $display("FAIL t6_reset: ss %b grant %b start %b want 11 00 0", ss_n_o, grant_o, spi_start_o); end
        reset_i = 1'b0; tick();
        clear_stats(); one_shot = 1'b1;
        req_i = 2'b10;
        run_bursts(1, 200, to);
        tests++; if (to) begin fails++; $display("FAIL t6_timeout: rises %0d want 1", n_rise); end
        tests++; if (grant_log[0] !== 2'b10 || n_rx !== 1 || rx_log[0] !== 8'hCC) begin fails++;
            $display("FAIL t6_after: grant %b rx %0d x %h want 10 1 x CC", grant_log[0], n_rx, rx_log[0]); end
    endtask

    initial begin
        reset_i = 1'b1; req_i = '0; last_i = '0; tx_data_i = '0; cpol_i = '0; cpha_i = '0;
        dvsr_i = '0; key = '0; len[0] = 1; len[1] = 1;
        for (int g = 0; g < 2; g++) for (int b = 0; b < 4; b++) bytes[g][b] = '0;
        test_reset();
        test_single_burst();
        test_multi_byte();
        test_round_robin();
        test_config();
        test_req_drop();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
